ibex_mem_responder: RTL and testbench

Word-addressed memory responder for the Ibex instruction or data bus; the counterpart of the core's LSU/fetch initiator. Accepts req/gnt transactions, services reads and byte-masked writes against an internal array, and returns in-order rvalid responses with SECDED integrity bits after a programmable latency. It sits outside the core, wired to the instr_* or data_* ports of the core top, in simulation benches and small FPGA systems.

---
 rtl/ibex_mem_responder_pkg.sv | 28 ++
 rtl/ibex_mem_responder_fifo.sv | 86 ++++++++
 rtl/prim_secded_inv_39_32_enc.sv | 24 ++
 rtl/ibex_mem_responder.sv | 154 +++++++++++++++
 tb/tb_ibex_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_mem_responder_pkg.sv
// ibex_mem_responder_pkg
// Shared types and helpers for the Ibex memory responder.
//   resp_entry_t : one queued response (read data, error flag, latency countdown)
//   MaxLatencyW  : width of the countdown, so RespLatency may be at most 16
//   in_range()   : unsigned window test used for address decode
package ibex_mem_responder_pkg;

    localparam int unsigned MaxLatencyW = 4;

    typedef struct packed {
        logic [31:0]            rdata;
        logic                   err;
        logic [MaxLatencyW-1:0] cnt;
    } resp_entry_t;

    // Unsigned subtraction makes an address below base wrap to a huge offset,
    // so it falls out of range like an address past the top.
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [31:0] offset;
        offset = addr - base;
        return (offset < size);
    endfunction

endpackage

// File: rtl/ibex_mem_responder_fifo.sv
// ibex_mem_responder_fifo
// Response FIFO in which every stored entry counts its own latency down in
// parallel, so entries queued behind the head mature while they wait.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_entry : enqueue one response this cycle
//   pop           : dequeue the head this cycle
//   head          : current head entry (meaningful when count != 0)
//   count         : number of stored entries
module ibex_mem_responder_fifo
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  resp_entry_t                  push_entry,
    input  logic                         pop,
    output resp_entry_t                  head,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    resp_entry_t       slots_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [CntW-1:0]   count_r;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] r;
        if (p == PtrW'(Depth - 1)) begin
            r = '0;
        end else begin
            r = p + PtrW'(1);
        end
        return r;
    endfunction

    // Slot storage: a push loads its slot, every other slot counts down to zero.
    // When full, a push lands on the head slot, which is popping the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                slots_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (push && (wr_ptr_r == PtrW'(i))) begin
                    slots_r[i] <= push_entry;
                end else if (slots_r[i].cnt != '0) begin
                    slots_r[i].cnt <= slots_r[i].cnt - MaxLatencyW'(1);
                end else begin
                    slots_r[i] <= slots_r[i];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = slots_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// prim_secded_inv_39_32_enc
// Inverted Hsiao SECDED (39,32) encoder. Check bits are inverted with a fixed
// pattern so that an all-zero word is not a valid codeword.
//   data_i [31:0] : data word
//   data_o [38:0] : {check bits, data}
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    // Each check bit is the parity of a fixed subset of data bits, then inverted.
    always_comb begin
        data_o     = {7'd0, data_i};
        data_o[32] = ^(data_o & 39'h00_2606_BD25);
        data_o[33] = ^(data_o & 39'h00_DEBA_8050);
        data_o[34] = ^(data_o & 39'h00_413D_89AA);
        data_o[35] = ^(data_o & 39'h00_3123_4ED1);
        data_o[36] = ^(data_o & 39'h00_C2C1_323B);
        data_o[37] = ^(data_o & 39'h00_2DCC_624C);
        data_o[38] = ^(data_o & 39'h00_9850_5586);
        data_o     = data_o ^ 39'h2A_0000_0000;
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
// Word-addressed memory answering Ibex req/gnt transactions. Reads and
// byte-masked writes are serviced at grant time; responses return in grant
// order after at least RespLatency cycles with SECDED check bits on rdata.
//   stall_i                       : suppresses grant while high
//   req_i/gnt_o                   : request handshake (grant is combinational)
//   we_i, be_i, addr_i, wdata_i   : access; addr_i[1:0] ignored
//   wdata_intg_i                  : check bits that must match wdata_i
//   rvalid_o, rdata_o, err_o      : response (cannot be stalled)
//   rdata_intg_o                  : check bits of rdata_o
//   err_count_o                   : saturating count of error responses
module ibex_mem_responder
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned MemSizeBytes   = 65536,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned RespLatency    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned NumWords = MemSizeBytes / 4;
    localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

    logic [31:0]     mem_r [NumWords];
    logic [31:0]     offset_s;
    logic [IdxW-1:0] word_idx_s;
    logic            in_range_s;
    logic [38:0]     wenc_s;
    logic [38:0]     renc_s;
    logic            intg_ok_s;
    logic            mem_we_s;
    resp_entry_t     push_entry_s;
    resp_entry_t     head_s;
    logic [CntW-1:0] fifo_count_s;
    logic            head_valid_s;
    logic [15:0]     err_count_r;
    logic            unused_bits_s;

    assign offset_s      = addr_i - BaseAddr;
    assign word_idx_s    = offset_s[IdxW+1:2];
    assign in_range_s    = in_range(addr_i, BaseAddr, 32'(MemSizeBytes));
    assign unused_bits_s = ^{offset_s, wenc_s[31:0], renc_s[31:0]};

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (wdata_i),
        .data_o (wenc_s)
    );
    assign intg_ok_s = (wenc_s[38:32] == wdata_intg_i);

    ibex_mem_responder_fifo #(
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (gnt_o),
        .push_entry (push_entry_s),
        .pop        (head_valid_s),
        .head       (head_s),
        .count      (fifo_count_s)
    );

    // The head leaves as soon as its countdown is done; the initiator cannot stall it.
    assign head_valid_s = (fifo_count_s != '0) && (head_s.cnt == '0);

    // Grant whenever a slot is free now or the head frees one this cycle.
    always_comb begin
        gnt_o = 1'b0;
        if (req_i && !stall_i &&
            ((fifo_count_s < CntW'(MaxOutstanding)) || head_valid_s)) begin
            gnt_o = 1'b1;
        end else begin
            gnt_o = 1'b0;
        end
    end

    assign mem_we_s = gnt_o && we_i && in_range_s && intg_ok_s;

    // Build the response at grant; reads sample the array now, so a read right
    // after a write to the same word sees the written data.
    always_comb begin
        push_entry_s     = '0;
        push_entry_s.cnt = MaxLatencyW'(RespLatency - 1);
        if (!in_range_s) begin
            push_entry_s.err = 1'b1;
        end else if (we_i) begin
            push_entry_s.err = ~intg_ok_s;
        end else begin
            push_entry_s.rdata = mem_r[word_idx_s];
        end
    end

    // Byte-masked array update; the array deliberately survives reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_r[word_idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Saturating count of error responses as they leave.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_r <= 16'd0;
        end else if (head_valid_s && head_s.err && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    // Response fields are zero whenever no response is presented.
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = 32'd0;
        err_o    = 1'b0;
        if (head_valid_s) begin
            rvalid_o = 1'b1;
            rdata_o  = head_s.rdata;
            err_o    = head_s.err;
        end else begin
            rvalid_o = 1'b0;
            rdata_o  = 32'd0;
            err_o    = 1'b0;
        end
    end

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (rdata_o),
        .data_o (renc_s)
    );
    assign rdata_intg_o = renc_s[38:32];
    assign err_count_o  = err_count_r;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// tb_ibex_mem_responder
// Two responders share stimulus wires: A (latency 1, depth 2, 64 KiB) and
// B (latency 3, depth 2, 4 KiB). A driver issues transactions and pushes the
// expected response (data, error, arrival cycle) into a per-responder queue;
// monitors compare whatever the responders present against those queues.
module tb_ibex_mem_responder;

    localparam logic [31:0] BASE   = 32'h0010_0000;
    localparam int unsigned SIZE_A = 65536;
    localparam int unsigned SIZE_B = 4096;
    localparam int          MAXO_A = 2;
    localparam int          LAT_A  = 1;
    localparam int          MAXO_B = 2;
    localparam int          LAT_B  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, we, req_a, req_b;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [6:0]  wintg;
    logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic [6:0]  rintg_a, rintg_b;
    logic [15:0] errcnt_a, errcnt_b;

    always #5 clk = ~clk;

    ibex_mem_responder #(.MemSizeBytes(SIZE_A), .BaseAddr(BASE),
                         .MaxOutstanding(MAXO_A), .RespLatency(LAT_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req_a), .gnt_o(gnt_a),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .rdata_intg_o(rintg_a),
        .err_o(err_a), .err_count_o(errcnt_a));

    ibex_mem_responder #(.MemSizeBytes(SIZE_B), .BaseAddr(BASE),
                         .MaxOutstanding(MAXO_B), .RespLatency(LAT_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req_b), .gnt_o(gnt_b),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .rdata_intg_o(rintg_b),
        .err_o(err_b), .err_count_o(errcnt_b));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        ea, eb;
    logic [31:0] mem_a[int unsigned];
    logic [31:0] mem_b[int unsigned];
    int          last_due_a = 0, last_due_b = 0;
    int          errs_a = 0, errs_b = 0;
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;
    int          arr_b[$];
    int          gr_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] ecc(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606BD25);
        p[1] = ^(d & 32'hDEBA8050);
        p[2] = ^(d & 32'h413D89AA);
        p[3] = ^(d & 32'h31234ED1);
        p[4] = ^(d & 32'hC2C1323B);
        p[5] = ^(d & 32'h2DCC624C);
        p[6] = ^(d & 32'h98505586);
        return p ^ 7'h2A;
    endfunction

    // Reference model: decide the response from the current bus inputs and
    // apply the access to the memory image.
    task automatic predict(input bit sel, output exp_t e);
        logic [31:0] off, w;
        int unsigned idx, size;
        bit inr, ok;
        size = sel ? SIZE_B : SIZE_A;
        off  = addr - BASE;
        inr  = (off < size);
        idx  = off >> 2;
        ok   = (wintg == ecc(wdata));
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (!inr) begin
            e.err = 1'b1;
        end else if (we) begin
            if (!ok) begin
                e.err = 1'b1;
            end else begin
                if (sel) w = mem_b.exists(idx) ? mem_b[idx] : 32'd0;
                else     w = mem_a.exists(idx) ? mem_a[idx] : 32'd0;
                for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
                if (sel) mem_b[idx] = w; else mem_a[idx] = w;
            end
        end else begin
            if (sel) e.rdata = mem_b.exists(idx) ? mem_b[idx] : 32'd0;
            else     e.rdata = mem_a.exists(idx) ? mem_a[idx] : 32'd0;
        end
        // Responses leave no earlier than grant+latency and never overtake.
        if (sel) begin
            e.due = (cyc + LAT_B > last_due_b + 1) ? cyc + LAT_B : last_due_b + 1;
            last_due_b = e.due;
        end else begin
            e.due = (cyc + LAT_A > last_due_a + 1) ? cyc + LAT_A : last_due_a + 1;
            last_due_a = e.due;
        end
    endtask

    // One bus cycle with req asserted towards the selected responder.
    task automatic step(input bit sel, output bit g, output bit ga);
        exp_t e;
        int pend;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        #1;
        pend = 0;
        if (sel) begin
            foreach (sb_b[i]) if (sb_b[i].due > cyc) pend++;
        end else begin
            foreach (sb_a[i]) if (sb_a[i].due > cyc) pend++;
        end
        g  = !stall && (pend < (sel ? MAXO_B : MAXO_A));
        ga = sel ? gnt_b : gnt_a;
        check(sel ? "gnt_b" : "gnt_a", 32'(ga), 32'(g));
        check(sel ? "gnt_a_idle" : "gnt_b_idle", 32'(sel ? gnt_a : gnt_b), 32'd0);
        if (g) begin
            predict(sel, e);
            if (sel) sb_b.push_back(e); else sb_a.push_back(e);
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [6:0] flip, input bit rnd_stall);
        bit g, ga;
        int n;
        we = w; addr = a; wdata = d; be = b; wintg = ecc(d) ^ flip;
        g = 1'b0;
        n = 0;
        while (!g && n < 64) begin
            stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            step(sel, g, ga);
            n++;
        end
        stall = 1'b0;
        if (!g) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_a.size() > 0 || sb_b.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Monitor A: every cycle either the expected response or nothing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                ea = sb_a.pop_front();
                check("rvalid_a", 32'(rvalid_a), 32'd1);
                if (rvalid_a) begin
                    check("rdata_a", rdata_a, ea.rdata);
                    check("err_a", 32'(err_a), 32'(ea.err));
                    check("rintg_a", 32'(rintg_a), 32'(ecc(ea.rdata)));
                    check("errcnt_a", 32'(errcnt_a), 32'(errs_a));
                    if (ea.err && errs_a < 65535) errs_a = errs_a + 1;
                end
            end else begin
                check("rvalid_a_idle", 32'(rvalid_a), 32'd0);
            end
        end
    end

    // Monitor B: same, and records arrival cycles for the timing test.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid_b) arr_b.push_back(cyc);
            if (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                eb = sb_b.pop_front();
                check("rvalid_b", 32'(rvalid_b), 32'd1);
                if (rvalid_b) begin
                    check("rdata_b", rdata_b, eb.rdata);
                    check("err_b", 32'(err_b), 32'(eb.err));
                    check("rintg_b", 32'(rintg_b), 32'(ecc(eb.rdata)));
                    check("errcnt_b", 32'(errcnt_b), 32'(errs_b));
                    if (eb.err && errs_b < 65535) errs_b = errs_b + 1;
                end
            end else begin
                check("rvalid_b_idle", 32'(rvalid_b), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, t0, tc, ng;
        bit          g, ga;
        logic [31:0] a, d;
        int          exp_gr[4];
        int          exp_arr[4];
        exp_gr  = '{0, 1, 3, 4};
        exp_arr = '{3, 4, 6, 7};

        rst_n = 1'b0; stall = 1'b0; we = 1'b0; req_a = 1'b0; req_b = 1'b0;
        be = 4'h0; addr = 32'd0; wdata = 32'd0; wintg = 7'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_gnt_a", 32'(gnt_a), 32'd0);
        check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rintg_a", 32'(rintg_a), 32'h2A);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_errcnt_a", 32'(errcnt_a), 32'd0);
        check("rst_rintg_b", 32'(rintg_b), 32'h2A);
        check("rst_errcnt_b", 32'(errcnt_b), 32'd0);

        // Full-word write then read, and a single-byte merge
        txn(0, 1, BASE, 32'hDEADBEEF, 4'hF, 7'd0, 0);
        txn(0, 0, BASE, 32'd0, 4'h0, 7'd0, 0);
        txn(0, 1, BASE + 32'd4, 32'h11223344, 4'hF, 7'd0, 0);
        txn(0, 1, BASE + 32'd4, 32'h000000AA, 4'b0001, 7'd0, 0);
        txn(0, 0, BASE + 32'd4, 32'd0, 4'hF, 7'd0, 0);
        drain();

        // Just past the top and just below the base
        txn(0, 0, BASE + 32'(SIZE_A), 32'd0, 4'hF, 7'd0, 0);
        txn(0, 0, BASE - 32'd4, 32'd0, 4'hF, 7'd0, 0);
        drain();
        check("errcnt_after_oor", 32'(errcnt_a), 32'd2);

        // Corrupted check bits: write refused, old data survives
        txn(0, 1, BASE + 32'd8, 32'h55667788, 4'hF, 7'd0, 0);
        txn(0, 1, BASE + 32'd8, 32'hCAFEF00D, 4'hF, 7'h01, 0);
        txn(0, 0, BASE + 32'd8, 32'd0, 4'hF, 7'd0, 0);
        drain();

        // Randomised traffic on A with random back-pressure
        for (int i = 0; i < 8; i++) txn(0, 1, BASE + 32'(16 + 4*i), $urandom, 4'hF, 7'd0, 0);
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a    = BASE + 32'(16 + 4*$urandom_range(0, 7));
            d    = $urandom;
            if (kind < 4) begin
                txn(0, 0, a, d, 4'($urandom_range(0, 15)), 7'd0, 1);
            end else if (kind < 8) begin
                txn(0, 1, a, d, 4'($urandom_range(0, 15)),
                    (kind == 7) ? 7'(1 << $urandom_range(0, 6)) : 7'd0, 1);
            end else begin
                a = (kind == 8) ? BASE + 32'(SIZE_A) + 32'(4*$urandom_range(0, 1000))
                                : BASE - 32'(4*$urandom_range(1, 1000));
                txn(0, 1'($urandom_range(0, 1)), a, d, 4'hF, 7'd0, 1);
            end
        end
        drain();

        // Latency 3, depth 2: request held six cycles
        for (int i = 0; i < 6; i++) txn(1, 1, BASE + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 7'd0, 0);
        drain();
        arr_b.delete();
        gr_b.delete();
        t0 = cyc;
        ng = 0;
        for (int c = 0; c < 6; c++) begin
            we = 1'b0; be = 4'hF; addr = BASE + 32'(4*ng); wdata = 32'd0; wintg = ecc(32'd0);
            tc = cyc;
            step(1, g, ga);
            if (ga) gr_b.push_back(tc - t0);
            if (g) ng++;
        end
        drain();
        check("grant_count_b", 32'(gr_b.size()), 32'd4);
        check("resp_count_b", 32'(arr_b.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gr_b.size()) check("grant_cycle_b", 32'(gr_b[i]), 32'(exp_gr[i]));
            if (i < arr_b.size()) check("resp_cycle_b", 32'(arr_b[i] - t0), 32'(exp_arr[i]));
        end

        // Reset with two responses in flight
        txn(1, 1, BASE + 32'd40, 32'h0BADCAFE, 4'hF, 7'd0, 0);
        txn(1, 0, BASE + 32'd40, 32'd0, 4'hF, 7'd0, 0);
        rst_n = 1'b0;
        sb_a.delete(); sb_b.delete();
        last_due_a = 0; last_due_b = 0; errs_a = 0; errs_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("errcnt_a_after_rst", 32'(errcnt_a), 32'd0);
        check("errcnt_b_after_rst", 32'(errcnt_b), 32'd0);
        txn(1, 0, BASE + 32'd40, 32'd0, 4'hF, 7'd0, 0);
        txn(1, 0, BASE + 32'd4, 32'd0, 4'hF, 7'd0, 0);
        txn(0, 0, BASE, 32'd0, 4'hF, 7'd0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
